// File: rtl/seven_seg_scan_controller.sv
// Multiplexed seven-segment scan controller: double-buffered digit word,
// one-hot digit scan with per-slot blanking and leading-zero suppression.
module seven_seg_scan_controller #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    enable,
   input  logic [4*NUM_DIGITS-1:0] digitsIn,
   input  logic                    loadStrobe,
   input  logic                    leadingZeroBlank,
   output logic [3:0]              BCDout,
   output logic [NUM_DIGITS-1:0]   digitEnable,
   output logic                    frameStart,
   output logic                    updatePending
);

   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned KW = $clog2(NUM_DIGITS);

   localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
   localparam logic [KW-1:0] K_LAST  = KW'(NUM_DIGITS - 1);

   logic [PW-1:0] p_q, p_d;
   logic [KW-1:0] k_q, k_d;
   logic          enq_q, enq_d;
   logic          boundary_c;

   logic [NUM_DIGITS-1:0][3:0] shadow_q;
   logic [NUM_DIGITS-1:0][3:0] display_q;
   logic                       pending_q;

   logic                  zero_run;
   logic [NUM_DIGITS-1:0] zero_from;
   logic                  suppress_c;
   logic                  lit_c;

   // Next prescaler / digit index; detects the frame boundary edge
   always_comb begin
      enq_d      = enable;
      p_d        = '0;
      k_d        = '0;
      boundary_c = 1'b0;
      if (enable) begin
         if (!enq_q) begin
            boundary_c = 1'b1;
         end else if (p_q == P_LAST) begin
            if (k_q == K_LAST) begin
               boundary_c = 1'b1;
            end else begin
               k_d = k_q + KW'(1);
            end
         end else begin
            p_d = p_q + PW'(1);
            k_d = k_q;
         end
      end
   end

   // Scan position and registered enable
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         enq_q <= 1'b0;
         p_q   <= '0;
         k_q   <= '0;
      end else begin
         enq_q <= enq_d;
         p_q   <= p_d;
         k_q   <= k_d;
      end
   end

   // Double buffer: shadow takes loads, display swaps only at frame boundaries
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shadow_q  <= '0;
         display_q <= '0;
         pending_q <= 1'b0;
      end else begin
         if (loadStrobe) begin
            shadow_q <= digitsIn;
         end
         if (boundary_c && pending_q) begin
            display_q <= shadow_q;
         end
         if (loadStrobe) begin
            pending_q <= 1'b1;
         end else if (boundary_c) begin
            pending_q <= 1'b0;
         end
      end
   end

   // zero_from[i] is set when digit i and every higher digit are zero
   always_comb begin
      zero_run  = 1'b1;
      zero_from = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run     = zero_run & (display_q[i] == 4'h0);
         zero_from[i] = zero_run;
      end
   end

   // Current slot is lit when scanning, past blanking and not suppressed
   always_comb begin
      suppress_c = leadingZeroBlank && (k_q != '0) && zero_from[k_q];
      lit_c      = enq_q && (p_q >= P_BLANK) && !suppress_c;
   end

   // Registered outputs decoded from the scan state
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         BCDout        <= 4'hF;
         digitEnable   <= '0;
         frameStart    <= 1'b0;
         updatePending <= 1'b0;
      end else begin
         BCDout        <= lit_c ? display_q[k_q] : 4'hF;
         digitEnable   <= lit_c ? (NUM_DIGITS'(1) << k_q) : '0;
         frameStart    <= enq_q && (p_q == '0) && (k_q == '0);
         updatePending <= pending_q;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench for seven_seg_scan_controller against a frame-time model.
module tb_seven_seg_scan_controller;

   localparam int unsigned N     = 4;
   localparam int unsigned RD    = 8;
   localparam int unsigned BL    = 2;
   localparam int unsigned FRAME = N * RD;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic          enable = 1'b0;
   logic [4*N-1:0] digitsIn = '0;
   logic          loadStrobe = 1'b0;
   logic          leadingZeroBlank = 1'b0;
   logic [3:0]    BCDout;
   logic [N-1:0]  digitEnable;
   logic          frameStart;
   logic          updatePending;

   typedef struct packed {
      logic [3:0]   bcd;
      logic [N-1:0] de;
      logic         fs;
      logic         up;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model state: frame time since the scan started, and the two buffers
   bit          m_en      = 1'b0;
   int          m_t       = 0;
   logic [15:0] m_shadow  = '0;
   logic [15:0] m_display = '0;
   bit          m_pending = 1'b0;

   seven_seg_scan_controller #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BL)
   ) dut (
      .clk             (clk),
      .resetN          (resetN),
      .enable          (enable),
      .digitsIn        (digitsIn),
      .loadStrobe      (loadStrobe),
      .leadingZeroBlank(leadingZeroBlank),
      .BCDout          (BCDout),
      .digitEnable     (digitEnable),
      .frameStart      (frameStart),
      .updatePending   (updatePending)
   );

   always #5 clk = ~clk;

   function automatic exp_t reset_vals();
      exp_t r;
      r.bcd = 4'hF;
      r.de  = '0;
      r.fs  = 1'b0;
      r.up  = 1'b0;
      return r;
   endfunction

   // Output expected for the state the model is in, with the live blank flag
   function automatic exp_t model_out(input bit lzb);
      exp_t e;
      int   k;
      int   ph;
      bit   sup;
      k   = m_t / RD;
      ph  = m_t % RD;
      sup = lzb && (k > 0) && ((m_display >> (4 * k)) == 16'h0);
      e.fs = m_en && (m_t == 0);
      e.up = m_pending;
      if (m_en && (ph >= BL) && !sup) begin
         e.de  = N'(1 << k);
         e.bcd = 4'((m_display >> (4 * k)) & 16'hF);
      end else begin
         e.de  = '0;
         e.bcd = 4'hF;
      end
      return e;
   endfunction

   // One clock of stimulus; records the expectation and advances the model
   task automatic step(input bit en, input bit ld, input logic [15:0] din,
                       input bit lzb, input bit rst);
      bit   boundary;
      exp_t r;
      @(negedge clk);
      enable           = en;
      loadStrobe       = ld;
      digitsIn         = din;
      leadingZeroBlank = lzb;
      resetN           = !rst;
      if (rst) begin
         m_en      = 1'b0;
         m_t       = 0;
         m_shadow  = '0;
         m_display = '0;
         m_pending = 1'b0;
         exp_q.push_back(reset_vals());
         #1;
         r = reset_vals();
         n_checks++;
         if ({BCDout, digitEnable, frameStart, updatePending} != r) begin
            n_fail++;
            $display("FAIL reset_immediate t=%0t got bcd=%h de=%b fs=%b up=%b want bcd=F de=0000 fs=0 up=0",
                     $time, BCDout, digitEnable, frameStart, updatePending);
         end
      end else begin
         exp_q.push_back(model_out(lzb));
         boundary = 1'b0;
         if (!en) begin
            m_en = 1'b0;
            m_t  = 0;
         end else if (!m_en) begin
            m_en     = 1'b1;
            m_t      = 0;
            boundary = 1'b1;
         end else begin
            m_t      = (m_t + 1) % FRAME;
            boundary = (m_t == 0);
         end
         if (boundary && m_pending) begin
            m_display = m_shadow;
            m_pending = 1'b0;
         end
         if (ld) begin
            m_shadow  = din;
            m_pending = 1'b1;
         end
      end
   endtask

   task automatic run(input int n, input bit lzb);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, lzb, 1'b0);
   endtask

   // Scan until the model sits at frame time tgt (bounded)
   task automatic advance_to(input int tgt, input bit lzb);
      int guard;
      guard = 0;
      while (!(m_en && (m_t == tgt)) && (guard < 200)) begin
         step(1'b1, 1'b0, 16'h0, lzb, 1'b0);
         guard++;
      end
      n_checks++;
      if (guard >= 200) begin
         n_fail++;
         $display("FAIL advance_to got t=%0d want t=%0d", m_t, tgt);
      end
   endtask

   // Monitor: compares every registered output sample against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({BCDout, digitEnable, frameStart, updatePending} != e) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t got bcd=%h de=%b fs=%b up=%b want bcd=%h de=%b fs=%b up=%b",
                        $time, BCDout, digitEnable, frameStart, updatePending,
                        e.bcd, e.de, e.fs, e.up);
            end
         end
      end
   end

   initial begin
      bit          en_s;
      bit          lzb_s;
      bit          rst_s;
      bit          ld_s;
      logic [15:0] din_s;

      // Reset held with enable high and toggling inputs
      for (int i = 0; i < 6; i++)
         step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);

      // Release: frame pulses one cycle after boundary, then every frame
      run(70, 1'b0);

      // Basic scan of 1234
      step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
      run(70, 1'b0);

      // Leading-zero suppression cases
      step(1'b1, 1'b1, 16'h0050, 1'b1, 1'b0);
      run(70, 1'b1);
      step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
      run(70, 1'b1);
      step(1'b1, 1'b1, 16'h0050, 1'b0, 1'b0);
      run(70, 1'b0);

      // Tearing: load mid-frame during digit 2, then a strobe on the boundary
      step(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
      run(40, 1'b0);
      advance_to(2 * RD + 3, 1'b0);
      step(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
      run(40, 1'b0);
      advance_to(RD + 1, 1'b0);
      step(1'b1, 1'b1, 16'h3333, 1'b0, 1'b0);
      advance_to(FRAME - 1, 1'b0);
      step(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0);
      run(70, 1'b0);

      // Enable dropped mid digit-2 slot, then restored
      advance_to(2 * RD + 4, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, (i == 2), 16'h5678, 1'b0, 1'b0);
      run(40, 1'b0);

      // Reset mid digit-2 slot with pending data, then resume
      step(1'b1, 1'b1, 16'h9876, 1'b0, 1'b0);
      advance_to(2 * RD + 5, 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      run(40, 1'b0);

      // Randomized traffic
      en_s  = 1'b1;
      lzb_s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 79) == 0) en_s = !en_s;
         if ($urandom_range(0, 49) == 0) lzb_s = !lzb_s;
         rst_s = ($urandom_range(0, 499) == 0);
         ld_s  = ($urandom_range(0, 19) == 0);
         din_s = 16'($urandom) >> (4 * $urandom_range(0, 4));
         step(en_s, ld_s, din_s, lzb_s, rst_s);
      end

      run(3, 1'b0);
      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d left want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
